// File: rtl/multi_button_shaper_if.sv
// Button shaper port bundle: raw active-low buttons in, shaped pulse/level/any-pulse out.
// The shaper is the slave; whoever supplies buttons and consumes events is the master.
interface multi_button_shaper_if #(
  parameter int NUM_BTNS = 4
);

  logic [NUM_BTNS-1:0] inButtons;
  logic [NUM_BTNS-1:0] outPulse;
  logic [NUM_BTNS-1:0] outLevel;
  logic                anyPulse;

  modport master (
    output inButtons,
    input  outPulse,
    input  outLevel,
    input  anyPulse
  );

  modport slave (
    input  inButtons,
    output outPulse,
    output outLevel,
    output anyPulse
  );

endinterface

// File: rtl/multi_button_shaper.sv
// N-channel pushbutton shaper: 2-FF sync, counter debounce, one-cycle press pulse, debounced level.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses while a button stays pressed.
module multi_button_shaper #(
  parameter int NUM_BTNS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_WIDTH       = 16,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_PERIOD   = 10000
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_button_shaper_if.slave  btn
);

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_PULSE, S_HELD, S_RPULSE, S_RHELD
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_PULSE, S_HELD
  } state_t;
`endif

  localparam longint CNT_MAX = (longint'(1) << CNT_WIDTH) - 1;

  // Every counter threshold has to fit in the shared counter width.
  if (CNT_WIDTH < 1 || DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > CNT_MAX ||
      longint'(REPEAT_DELAY) > CNT_MAX || longint'(REPEAT_PERIOD) > CNT_MAX) begin : g_bad_params
    $error("multi_button_shaper: CNT_WIDTH too small for configured cycle counts");
  end

  logic [NUM_BTNS-1:0] sync1;
  logic [NUM_BTNS-1:0] sync2;
  logic [NUM_BTNS-1:0] levelVec;
  logic [NUM_BTNS-1:0] pulseVec;
  logic [NUM_BTNS-1:0] pulseNextVec;
  logic                anyQ;

  // Sync FFs reset to the released (high) level so a held button reads as a fresh press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn.inButtons;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anyQ <= 1'b0;
    end else begin
      anyQ <= |pulseNextVec;
    end
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    logic [CNT_WIDTH-1:0] dbCnt;
    logic                 levelQ;
    logic                 differ;
    logic                 pulseQ;
    logic                 pulseNext;
    state_t               state;
    state_t               stateNext;

    assign differ = (~sync2[i]) != levelQ;

    // The level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dbCnt  <= '0;
        levelQ <= 1'b0;
      end else if (!differ) begin
        dbCnt  <= '0;
      end else if (dbCnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
        dbCnt  <= '0;
        levelQ <= ~levelQ;
      end else begin
        dbCnt  <= dbCnt + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state  <= S_IDLE;
        pulseQ <= 1'b0;
      end else begin
        state  <= stateNext;
        pulseQ <= pulseNext;
      end
    end

`ifdef BTN_AUTOREPEAT_EN
    logic [CNT_WIDTH-1:0] rptCnt;

    // Counts cycles spent in a held state; the -2 in the thresholds below accounts for
    // the entry cycle (count 0) and the registered pulse one cycle after the decision.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rptCnt <= '0;
      end else if ((stateNext == S_HELD || stateNext == S_RHELD) && stateNext == state) begin
        rptCnt <= rptCnt + 1'b1;
      end else begin
        rptCnt <= '0;
      end
    end
`endif

    always_comb begin
      stateNext = state;
      case (state)
        S_IDLE:   if (levelQ) stateNext = S_PULSE;
        S_PULSE:  stateNext = S_HELD;
`ifdef BTN_AUTOREPEAT_EN
        S_HELD: begin
          if (!levelQ) stateNext = S_IDLE;
          else if (rptCnt == CNT_WIDTH'(REPEAT_DELAY - 2)) stateNext = S_RPULSE;
        end
        S_RPULSE: stateNext = S_RHELD;
        S_RHELD: begin
          if (!levelQ) stateNext = S_IDLE;
          else if (rptCnt == CNT_WIDTH'(REPEAT_PERIOD - 2)) stateNext = S_RPULSE;
        end
`else
        S_HELD:   if (!levelQ) stateNext = S_IDLE;
`endif
        default:  stateNext = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state and registered, so they align with the state.
    always_comb begin
      pulseNext = 1'b0;
      if (stateNext == S_PULSE) pulseNext = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
      if (stateNext == S_RPULSE) pulseNext = 1'b1;
`endif
    end

    assign pulseNextVec[i] = pulseNext;
    assign pulseVec[i]     = pulseQ;
    assign levelVec[i]     = levelQ;
  end

  assign btn.outPulse = pulseVec;
  assign btn.outLevel = levelVec;
  assign btn.anyPulse = anyQ;

endmodule

// File: tb/tb_multi_button_shaper.sv
// Directed self-checking bench for multi_button_shaper (DEBOUNCE_CYCLES=4, repeat 20/8).
// Expected pulse cycles are hand-computed; repeat expectations follow BTN_AUTOREPEAT_EN.
module tb_multi_button_shaper;

  localparam int NUM_BTNS   = 4;
  localparam int DEB        = 4;
  localparam int RPT_DELAY  = 20;
  localparam int RPT_PERIOD = 8;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  multi_button_shaper_if #(.NUM_BTNS(NUM_BTNS)) btnIf ();

  multi_button_shaper #(
    .NUM_BTNS        (NUM_BTNS),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_WIDTH       (16),
    .REPEAT_DELAY    (RPT_DELAY),
    .REPEAT_PERIOD   (RPT_PERIOD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .btn (btnIf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_BTNS-1:0] buttons);
    btnIf.inButtons = buttons;
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) step();
  endtask

  // Press applied at cycle 0: level from cycle 6, one pulse at cycle 7.
  task automatic checkPressWindow(input string name, input int lastCycle, input logic [NUM_BTNS-1:0] mask);
    for (int k = 1; k <= lastCycle; k++) begin
      step();
      checkOutput($sformatf("%s pulse c%0d", name, k), 32'(btnIf.outPulse), (k == 7) ? 32'(mask) : 32'd0);
      checkOutput($sformatf("%s any c%0d", name, k), 32'(btnIf.anyPulse), (k == 7) ? 32'd1 : 32'd0);
      checkOutput($sformatf("%s level c%0d", name, k), 32'(btnIf.outLevel), (k >= 6) ? 32'(mask) : 32'd0);
    end
  endtask

  function automatic logic expRepeat(input int k);
`ifdef BTN_AUTOREPEAT_EN
    return (k == 7 || k == 27 || k == 35 || k == 43 || k == 51 || k == 59);
`else
    return (k == 7);
`endif
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic bounceLow;

    rst = 1'b1;
    applyStimulus(4'b0000);
    #1 rst = 1'b0;
    waitCycles(3);
    checkOutput("reset pulse", 32'(btnIf.outPulse), 32'd0);
    checkOutput("reset level", 32'(btnIf.outLevel), 32'd0);
    checkOutput("reset any", 32'(btnIf.anyPulse), 32'd0);

    // All buttons held through reset release count as a fresh press.
    rst = 1'b1;
    checkPressWindow("rstrel", 10, 4'b1111);
    applyStimulus(4'b1111);
    waitCycles(8);
    checkOutput("rstrel released level", 32'(btnIf.outLevel), 32'd0);

    $display("[TB] clean press on button 1");
    applyStimulus(4'b1101);
    checkPressWindow("press", 26, 4'b0010);
    waitCycles(4);
    applyStimulus(4'b1111);
    waitCycles(5);
    checkOutput("release level c35", 32'(btnIf.outLevel[1]), 32'd1);
    step();
    checkOutput("release level c36", 32'(btnIf.outLevel[1]), 32'd0);
    waitCycles(10);

    $display("[TB] bounce on button 0");
    applyStimulus(4'b1110);
    for (int k = 1; k <= 15; k++) begin
      step();
      checkOutput($sformatf("bounce pulse c%0d", k), 32'(btnIf.outPulse), 32'd0);
      checkOutput($sformatf("bounce level c%0d", k), 32'(btnIf.outLevel), 32'd0);
      bounceLow = (k <= 2) || (k >= 4 && k <= 6);
      applyStimulus(bounceLow ? 4'b1110 : 4'b1111);
    end

    $display("[TB] simultaneous press on buttons 2 and 3");
    applyStimulus(4'b0011);
    checkPressWindow("simul", 12, 4'b1100);

    // Async reset pulse between edges while both buttons stay held.
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst pulse", 32'(btnIf.outPulse), 32'd0);
    checkOutput("midrst level", 32'(btnIf.outLevel), 32'd0);
    checkOutput("midrst any", 32'(btnIf.anyPulse), 32'd0);
    #1 rst = 1'b1;
    checkPressWindow("rstheld", 12, 4'b1100);
    applyStimulus(4'b1111);
    waitCycles(10);

    $display("[TB] long hold on button 0");
    applyStimulus(4'b1110);
    for (int k = 1; k <= 75; k++) begin
      step();
      checkOutput($sformatf("hold pulse c%0d", k), 32'(btnIf.outPulse), expRepeat(k) ? 32'd1 : 32'd0);
      checkOutput($sformatf("hold any c%0d", k), 32'(btnIf.anyPulse), expRepeat(k) ? 32'd1 : 32'd0);
      checkOutput($sformatf("hold level c%0d", k), 32'(btnIf.outLevel), (k >= 6 && k < 66) ? 32'd1 : 32'd0);
      if (k == 60) applyStimulus(4'b1111);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
